// File: rtl/keypad_pkg.sv
// keypad_pkg: shared definitions for the doorlock keypad path.
//   state_t          - scanner FSM states (SCAN / DEBOUNCE / HELD)
//   KEY_*            - logical key values used by the doorlock FSM
//   KEY_MAP          - scan code (row*4+col) to logical key translation
//   scan_to_key()    - lookup helper over KEY_MAP
//   lowest_low_row() - picks the lowest-numbered active-low row
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } state_t;

    localparam logic [3:0] KEY_0    = 4'h0;
    localparam logic [3:0] KEY_1    = 4'h1;
    localparam logic [3:0] KEY_2    = 4'h2;
    localparam logic [3:0] KEY_3    = 4'h3;
    localparam logic [3:0] KEY_4    = 4'h4;
    localparam logic [3:0] KEY_5    = 4'h5;
    localparam logic [3:0] KEY_6    = 4'h6;
    localparam logic [3:0] KEY_7    = 4'h7;
    localparam logic [3:0] KEY_8    = 4'h8;
    localparam logic [3:0] KEY_9    = 4'h9;
    localparam logic [3:0] KEY_A    = 4'hA;
    localparam logic [3:0] KEY_B    = 4'hB;
    localparam logic [3:0] KEY_C    = 4'hC;
    localparam logic [3:0] KEY_D    = 4'hD;
    localparam logic [3:0] KEY_STAR = 4'hE;
    localparam logic [3:0] KEY_HASH = 4'hF;

    // Physical layout of the 4x4 pad, indexed by scan code row*4+col.
    //   row0: 1 2 3 A   row1: 4 5 6 B   row2: 7 8 9 C   row3: * 0 # D
    localparam logic [3:0] KEY_MAP [16] = '{
        KEY_1,    KEY_2, KEY_3,    KEY_A,
        KEY_4,    KEY_5, KEY_6,    KEY_B,
        KEY_7,    KEY_8, KEY_9,    KEY_C,
        KEY_STAR, KEY_0, KEY_HASH, KEY_D
    };

    function automatic logic [3:0] scan_to_key(input logic [3:0] code);
        scan_to_key = KEY_MAP[code];
    endfunction

    // Rows are active-low; the lowest index wins when several are low.
    function automatic logic [1:0] lowest_low_row(input logic [3:0] rows);
        lowest_low_row = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!rows[i]) lowest_low_row = 2'(i);
        end
    endfunction

endpackage

// File: rtl/row_sync.sv
// row_sync: 4-bit two-stage synchronizer for the keypad row returns.
//   clk, reset_n : clock, asynchronous active-low reset (flops reset to 1)
//   d            : raw asynchronous rows (active-low, pulled up)
//   q            : synchronized rows, two cycles behind d
module row_sync (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] d,
    output logic [3:0] q
);

    logic [3:0] meta;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta <= 4'hF;
            q    <= 4'hF;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: column-strobe scanner and debouncer for the 4x4 doorlock pad.
//   clk, reset_n : clock, asynchronous active-low reset
//   scan_en      : 1 = scanning, 0 = pad idle (all columns released)
//   row_in       : raw row returns, active-low, asynchronous
//   col_out      : column strobes, active-low, at most one low
//   key_valid    : one-cycle strobe per accepted press
//   key_code     : row*4+col of the last accepted press
//   key_held     : high from the accepting strobe until release is debounced
//   state_dbg    : current FSM state, for observation only
//
// Handshake: key_valid is a push-only strobe with no ready/backpressure; the
// consumer must capture key_code in the cycle key_valid is high. key_code then
// stays stable until the next key_valid.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 20000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       scan_en,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic       key_valid,
    output logic [3:0] key_code,
    output logic       key_held,
    output state_t     state_dbg
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int BW = $clog2(DEBOUNCE_CNT);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] STAB_LAST  = BW'(DEBOUNCE_CNT - 1);

    logic [3:0]    rows_s;
    state_t        state, state_nxt;
    logic [1:0]    col_idx, col_nxt;
    logic [1:0]    row_idx, row_nxt;
    logic [DW-1:0] dwell_cnt, dwell_nxt;
    // Shared by DEBOUNCE (press stability) and HELD (release stability).
    logic [BW-1:0] stab_cnt, stab_nxt;
    logic          valid_q, valid_nxt;
    logic [3:0]    code_q, code_nxt;
    logic          held_q, held_nxt;

    row_sync u_row_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (row_in),
        .q       (rows_s)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= SCAN;
            col_idx   <= 2'd0;
            row_idx   <= 2'd0;
            dwell_cnt <= '0;
            stab_cnt  <= '0;
            valid_q   <= 1'b0;
            code_q    <= 4'd0;
            held_q    <= 1'b0;
        end else begin
            state     <= state_nxt;
            col_idx   <= col_nxt;
            row_idx   <= row_nxt;
            dwell_cnt <= dwell_nxt;
            stab_cnt  <= stab_nxt;
            valid_q   <= valid_nxt;
            code_q    <= code_nxt;
            held_q    <= held_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        col_nxt   = col_idx;
        row_nxt   = row_idx;
        dwell_nxt = dwell_cnt;
        stab_nxt  = stab_cnt;
        valid_nxt = 1'b0;
        code_nxt  = code_q;
        held_nxt  = held_q;

        if (!scan_en) begin
            state_nxt = SCAN;
            col_nxt   = 2'd0;
            dwell_nxt = '0;
            stab_nxt  = '0;
            held_nxt  = 1'b0;
        end else begin
            case (state)
                SCAN: begin
                    // Rows are only looked at on the last dwell cycle, so the
                    // column has settled and the synchronizer has caught up.
                    if (dwell_cnt == DWELL_LAST) begin
                        dwell_nxt = '0;
                        if (rows_s == 4'hF) begin
                            col_nxt = col_idx + 2'd1;
                        end else begin
                            row_nxt   = lowest_low_row(rows_s);
                            stab_nxt  = '0;
                            state_nxt = DEBOUNCE;
                        end
                    end else begin
                        dwell_nxt = dwell_cnt + DW'(1);
                    end
                end
                DEBOUNCE: begin
                    if (rows_s[row_idx]) begin
                        stab_nxt  = '0;
                        col_nxt   = col_idx + 2'd1;
                        dwell_nxt = '0;
                        state_nxt = SCAN;
                    end else if (stab_cnt == STAB_LAST) begin
                        stab_nxt  = '0;
                        valid_nxt = 1'b1;
                        code_nxt  = {row_idx, col_idx};
                        held_nxt  = 1'b1;
                        state_nxt = HELD;
                    end else begin
                        stab_nxt = stab_cnt + BW'(1);
                    end
                end
                HELD: begin
                    // Any low row in the held column (including a second key)
                    // restarts the release window.
                    if (rows_s != 4'hF) begin
                        stab_nxt = '0;
                    end else if (stab_cnt == STAB_LAST) begin
                        stab_nxt  = '0;
                        held_nxt  = 1'b0;
                        col_nxt   = col_idx + 2'd1;
                        dwell_nxt = '0;
                        state_nxt = SCAN;
                    end else begin
                        stab_nxt = stab_cnt + BW'(1);
                    end
                end
                default: begin
                    state_nxt = SCAN;
                end
            endcase
        end
    end

    // Gating with scan_en makes disable take effect in the same cycle; the
    // registers themselves clear on the following edge.
    assign col_out   = scan_en ? ~(4'b0001 << col_idx) : 4'b1111;
    assign key_valid = valid_q & scan_en;
    assign key_held  = held_q & scan_en;
    assign key_code  = code_q;
    assign state_dbg = state;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_CNT=8. A keypad model
// pulls row r low whenever key (r,c) is pressed and column c is strobed low.
// Time base: inputs change and outputs are checked on falling edges; "cycle k"
// is the falling edge k clocks after reset release. Row changes reach the
// FSM two cycles late through the synchronizer.
module tb_keypad_scanner;
    import keypad_pkg::*;

    logic        clk;
    logic        reset_n;
    logic        scan_en;
    logic [3:0]  row_in;
    logic [3:0]  col_out;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        key_held;
    state_t      state_dbg;
    logic [15:0] pressed;

    int errors = 0;
    int checks = 0;

    keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CNT(8)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .scan_en   (scan_en),
        .row_in    (row_in),
        .col_out   (col_out),
        .key_valid (key_valid),
        .key_code  (key_code),
        .key_held  (key_held),
        .state_dbg (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // keypad matrix model
    always_comb begin
        row_in = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
            end
        end
    end

    // driver: reset, returns on the falling edge where reset is released
    task automatic do_reset();
        reset_n = 1'b0;
        scan_en = 1'b1;
        pressed = 16'h0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        scan_en = 1'b1;
        pressed = 16'h0;
        repeat (2) @(negedge clk);
        checks++; if (col_out !== 4'b1110) begin errors++; $display("FAIL reset_col: got %b want 1110", col_out); end
        checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", key_valid); end
        checks++; if (key_code !== 4'd0) begin errors++; $display("FAIL reset_code: got %0d want 0", key_code); end
        checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL reset_held: got %b want 0", key_held); end
        checks++; if (state_dbg !== SCAN) begin errors++; $display("FAIL reset_state: got %0d want %0d", state_dbg, SCAN); end
        reset_n = 1'b1;
    endtask

    // no key: columns rotate every 4 cycles, no events
    task automatic test_scan_idle();
        int nvalid;
        logic [3:0] exp_col;
        logic [3:0] one;
        nvalid = 0;
        one = 4'b0001;
        do_reset();
        for (int k = 0; k < 20; k++) begin
            if (k > 0) @(negedge clk);
            exp_col = ~(one << ((k / 4) % 4));
            if (key_valid) nvalid++;
            checks++; if (col_out !== exp_col) begin errors++; $display("FAIL idle_col[%0d]: got %b want %b", k, col_out, exp_col); end
        end
        checks++; if (nvalid != 0) begin errors++; $display("FAIL idle_valid: got %0d pulses want 0", nvalid); end
    endtask

    // key 6 (row1,col2) held 30 cycles: DEBOUNCE entered at cycle 12, event at 20
    task automatic test_press();
        int nvalid;
        nvalid = 0;
        do_reset();
        pressed[6] = 1'b1;
        for (int k = 1; k <= 44; k++) begin
            @(negedge clk);
            if (key_valid) nvalid++;
            if (k == 11) begin
                checks++; if (state_dbg !== SCAN) begin errors++; $display("FAIL press_pre_state: got %0d want %0d", state_dbg, SCAN); end
            end
            if (k == 12) begin
                checks++; if (state_dbg !== DEBOUNCE) begin errors++; $display("FAIL press_db_entry: got %0d want %0d", state_dbg, DEBOUNCE); end
                checks++; if (col_out !== 4'b1011) begin errors++; $display("FAIL press_col_lock: got %b want 1011", col_out); end
            end
            if (k == 19) begin
                checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL press_early_valid: got %b want 0", key_valid); end
            end
            if (k == 20) begin
                checks++; if (key_valid !== 1'b1) begin errors++; $display("FAIL press_valid: got %b want 1", key_valid); end
                checks++; if (key_code !== 4'd6) begin errors++; $display("FAIL press_code: got %0d want 6", key_code); end
                checks++; if (key_held !== 1'b1) begin errors++; $display("FAIL press_held: got %b want 1", key_held); end
            end
            if (k == 21) begin
                checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL press_pulse_len: got %b want 0", key_valid); end
                checks++; if (state_dbg !== HELD) begin errors++; $display("FAIL press_state_held: got %0d want %0d", state_dbg, HELD); end
            end
            if (k == 29) begin
                checks++; if (col_out !== 4'b1011) begin errors++; $display("FAIL press_col_held: got %b want 1011", col_out); end
            end
            if (k == 30) pressed[6] = 1'b0;
            if (k == 39) begin
                checks++; if (key_held !== 1'b1) begin errors++; $display("FAIL press_held_late: got %b want 1", key_held); end
            end
            if (k == 40) begin
                checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL press_release: got %b want 0", key_held); end
                checks++; if (col_out !== 4'b0111) begin errors++; $display("FAIL press_next_col: got %b want 0111", col_out); end
            end
        end
        checks++; if (nvalid != 1) begin errors++; $display("FAIL press_count: got %0d pulses want 1", nvalid); end
    endtask

    // key 1 (row0,col1) low for 3 cycles: rejected, scan moves to col2
    task automatic test_bounce();
        int nvalid;
        nvalid = 0;
        do_reset();
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (key_valid) nvalid++;
            if (k == 8) begin
                checks++; if (state_dbg !== DEBOUNCE) begin errors++; $display("FAIL bounce_db_entry: got %0d want %0d", state_dbg, DEBOUNCE); end
            end
            if (k == 10) begin
                checks++; if (col_out !== 4'b1101) begin errors++; $display("FAIL bounce_col_hold: got %b want 1101", col_out); end
            end
            if (k == 11) begin
                checks++; if (state_dbg !== SCAN) begin errors++; $display("FAIL bounce_abort: got %0d want %0d", state_dbg, SCAN); end
                checks++; if (col_out !== 4'b1011) begin errors++; $display("FAIL bounce_next_col: got %b want 1011", col_out); end
            end
            if (k == 5) pressed[1] = 1'b1;
            if (k == 8) pressed[1] = 1'b0;
        end
        checks++; if (nvalid != 0) begin errors++; $display("FAIL bounce_count: got %0d pulses want 0", nvalid); end
        checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL bounce_held: got %b want 0", key_held); end
    endtask

    // release bounce: high 4, low 2, final high at cycle 28 -> held drops at 38
    // (2 synchronizer cycles + 8 stable cycles)
    task automatic test_release_bounce();
        int nvalid;
        nvalid = 0;
        do_reset();
        pressed[6] = 1'b1;
        for (int k = 1; k <= 50; k++) begin
            @(negedge clk);
            if (key_valid) nvalid++;
            if (k == 20) begin
                checks++; if (key_valid !== 1'b1) begin errors++; $display("FAIL rel_valid: got %b want 1", key_valid); end
            end
            if (k == 30) begin
                checks++; if (state_dbg !== HELD) begin errors++; $display("FAIL rel_still_held: got %0d want %0d", state_dbg, HELD); end
            end
            if (k == 37) begin
                checks++; if (key_held !== 1'b1) begin errors++; $display("FAIL rel_held_37: got %b want 1", key_held); end
            end
            if (k == 38) begin
                checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL rel_held_38: got %b want 0", key_held); end
            end
            if (k == 22) pressed[6] = 1'b0;
            if (k == 26) pressed[6] = 1'b1;
            if (k == 28) pressed[6] = 1'b0;
        end
        checks++; if (nvalid != 1) begin errors++; $display("FAIL rel_count: got %0d pulses want 1", nvalid); end
    endtask

    // keys 3 and 11 (rows 0,2 on col3), then key 5 (col1) added during HELD
    task automatic test_multi_key();
        int nvalid_mid;
        nvalid_mid = 0;
        do_reset();
        pressed[3]  = 1'b1;
        pressed[11] = 1'b1;
        for (int k = 1; k <= 70; k++) begin
            @(negedge clk);
            if (k > 24 && k < 66 && key_valid) nvalid_mid++;
            if (k == 24) begin
                checks++; if (key_valid !== 1'b1) begin errors++; $display("FAIL multi_valid1: got %b want 1", key_valid); end
                checks++; if (key_code !== 4'd3) begin errors++; $display("FAIL multi_code1: got %0d want 3", key_code); end
            end
            if (k == 50) begin
                checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL multi_release: got %b want 0", key_held); end
                checks++; if (col_out !== 4'b1110) begin errors++; $display("FAIL multi_wrap_col: got %b want 1110", col_out); end
            end
            if (k == 60) begin
                checks++; if (key_code !== 4'd3) begin errors++; $display("FAIL multi_code_kept: got %0d want 3", key_code); end
                checks++; if (state_dbg !== DEBOUNCE) begin errors++; $display("FAIL multi_db2: got %0d want %0d", state_dbg, DEBOUNCE); end
            end
            if (k == 66) begin
                checks++; if (key_valid !== 1'b1) begin errors++; $display("FAIL multi_valid2: got %b want 1", key_valid); end
                checks++; if (key_code !== 4'd5) begin errors++; $display("FAIL multi_code2: got %0d want 5", key_code); end
            end
            if (k == 26) pressed[5] = 1'b1;
            if (k == 40) begin
                pressed[3]  = 1'b0;
                pressed[11] = 1'b0;
            end
        end
        checks++; if (nvalid_mid != 0) begin errors++; $display("FAIL multi_hidden: got %0d pulses want 0", nvalid_mid); end
    endtask

    // scan_en dropped in HELD, re-enabled, then reset pulsed in DEBOUNCE
    task automatic test_abort();
        int nvalid;
        nvalid = 0;
        do_reset();
        pressed[6] = 1'b1;
        for (int k = 1; k <= 50; k++) begin
            @(negedge clk);
            if (key_valid) nvalid++;
            if (k == 25) begin
                checks++; if (key_held !== 1'b1) begin errors++; $display("FAIL abort_pre_held: got %b want 1", key_held); end
                scan_en = 1'b0;
                #1;
                checks++; if (col_out !== 4'b1111) begin errors++; $display("FAIL abort_dis_col: got %b want 1111", col_out); end
                checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL abort_dis_held: got %b want 0", key_held); end
            end
            if (k == 26) begin
                checks++; if (state_dbg !== SCAN) begin errors++; $display("FAIL abort_dis_state: got %0d want %0d", state_dbg, SCAN); end
                checks++; if (key_code !== 4'd6) begin errors++; $display("FAIL abort_code_kept: got %0d want 6", key_code); end
                scan_en = 1'b1;
                #1;
                checks++; if (col_out !== 4'b1110) begin errors++; $display("FAIL abort_restart_col: got %b want 1110", col_out); end
            end
            if (k == 30) begin
                checks++; if (col_out !== 4'b1101) begin errors++; $display("FAIL abort_col1: got %b want 1101", col_out); end
            end
            if (k == 38) begin
                checks++; if (state_dbg !== DEBOUNCE) begin errors++; $display("FAIL abort_db_again: got %0d want %0d", state_dbg, DEBOUNCE); end
            end
            if (k == 40) begin
                reset_n = 1'b0;
                #1;
                checks++; if (col_out !== 4'b1110) begin errors++; $display("FAIL abort_rst_col: got %b want 1110", col_out); end
                checks++; if (key_code !== 4'd0) begin errors++; $display("FAIL abort_rst_code: got %0d want 0", key_code); end
                checks++; if (state_dbg !== SCAN) begin errors++; $display("FAIL abort_rst_state: got %0d want %0d", state_dbg, SCAN); end
            end
            if (k == 43) begin
                pressed[6] = 1'b0;
                reset_n = 1'b1;
            end
        end
        checks++; if (nvalid != 1) begin errors++; $display("FAIL abort_count: got %0d pulses want 1", nvalid); end
        checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL abort_end_held: got %b want 0", key_held); end
    endtask

    initial begin
        reset_n = 1'b0;
        scan_en = 1'b1;
        pressed = 16'h0;
        test_reset();
        test_scan_idle();
        test_press();
        test_bounce();
        test_release_bounce();
        test_multi_key();
        test_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
